// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, size codes, IO select bits and FSM encodings for mem_ctrl
package mem_ctrl_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] IO_SEL = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_STORE = 2'd3;
  typedef struct packed {
    logic we;
    logic [DATA_WIDTH-1:0] addr;
    logic [1:0] size;
    logic [DATA_WIDTH-1:0] wdata;
  } lsb_req_t;
  // Size code 11 is illegal and falls through to a full word.
  function automatic logic [2:0] size_beats(input logic [1:0] size);
    return size == SIZE_B ? 3'd1 : size == SIZE_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO controller arbitrating LSB (priority) and instruction fetch
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_fetch_ce,
  input  logic [DATA_WIDTH-1:0] in_fetch_pc,
  output logic                  out_fetch_ce,
  output logic [DATA_WIDTH-1:0] out_fetch_instr,
  input  logic                  in_lsb_ce,
  input  logic                  in_lsb_we,
  input  logic [DATA_WIDTH-1:0] in_lsb_addr,
  input  logic [1:0]            in_lsb_size,
  input  logic [DATA_WIDTH-1:0] in_lsb_wdata,
  output logic                  out_lsb_ce,
  output logic [DATA_WIDTH-1:0] out_lsb_rdata,
  input  logic                  in_rob_misbranch,
  input  logic                  in_io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);
  logic [1:0] state_q, state_d;
  logic [2:0] stage_q, stage_d, beats_q, beats_d;
  logic [DATA_WIDTH-1:0] base_q, base_d, wdata_q, wdata_d, asm_q, asm_d;
  logic fetch_pend_q, fetch_pend_d, lsb_pend_q, lsb_pend_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, fetch_pc_now;
  lsb_req_t lsb_req_q, lsb_req_d, lsb_now;
  logic fetch_ce_q, fetch_ce_d, lsb_ce_q, lsb_ce_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d, rdata_q, rdata_d, rd_word;
  logic lsb_new, fetch_new, reading, storing, io_stall, last_rd, last_st, abort, free, rd_done;
  logic [4:0] cap_sh;
  always_comb begin
    // A misbranch drops a same-cycle fetch or load pulse; stores always survive.
    lsb_new = in_lsb_ce && (in_lsb_we || !in_rob_misbranch);
    fetch_new = in_fetch_ce && !in_rob_misbranch;
    lsb_now = lsb_new ? lsb_req_t'{in_lsb_we, in_lsb_addr, in_lsb_size, in_lsb_wdata} : lsb_req_q;
    lsb_req_d = lsb_now;
    lsb_pend_d = lsb_new || (lsb_pend_q && (lsb_req_q.we || !in_rob_misbranch));
    fetch_pc_now = fetch_new ? in_fetch_pc : fetch_pc_q;
    fetch_pc_d = fetch_pc_now;
    fetch_pend_d = fetch_new || (fetch_pend_q && !in_rob_misbranch);
    reading = state_q == ST_FETCH || state_q == ST_LOAD;
    storing = state_q == ST_STORE;
    io_stall = storing && base_q[17:16] == IO_SEL && in_io_buffer_full;
    last_rd = reading && stage_q == beats_q;
    last_st = storing && !io_stall && stage_q == beats_q - 3'd1;
    abort = reading && in_rob_misbranch;
    rd_done = last_rd && !abort;
    free = state_q == ST_IDLE || rd_done || last_st;
    // The byte addressed in the previous beat arrives now.
    cap_sh = {stage_q[1:0] - 2'd1, 3'b000};
    rd_word = asm_q;
    if (reading && stage_q != 3'd0) rd_word[cap_sh +: 8] = mem_din;
    fetch_ce_d = rd_done && state_q == ST_FETCH;
    lsb_ce_d = (rd_done && state_q == ST_LOAD) || last_st;
    instr_d = fetch_ce_d ? rd_word : instr_q;
    rdata_d = rd_done && state_q == ST_LOAD ? rd_word : rdata_q;
    asm_d = rd_word;
    state_d = abort ? ST_IDLE : state_q;
    stage_d = abort ? 3'd0 : (reading || (storing && !io_stall)) ? stage_q + 3'd1 : stage_q;
    base_d = base_q;
    beats_d = beats_q;
    wdata_d = wdata_q;
    // Finishing an access picks the next one in the same edge so ops run back to back.
    if (free) begin
      asm_d = ZERO_DATA;
      stage_d = 3'd0;
      state_d = lsb_pend_d ? (lsb_now.we ? ST_STORE : ST_LOAD) : fetch_pend_d ? ST_FETCH : ST_IDLE;
      base_d = lsb_pend_d ? lsb_now.addr : fetch_pc_now;
      beats_d = lsb_pend_d ? size_beats(lsb_now.size) : 3'd4;
      wdata_d = lsb_now.wdata;
      fetch_pend_d = fetch_pend_d && lsb_pend_d;
      lsb_pend_d = FALSE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= 3'd0;
      beats_q <= 3'd0;
      base_q <= ZERO_DATA;
      wdata_q <= ZERO_DATA;
      asm_q <= ZERO_DATA;
      fetch_pend_q <= FALSE;
      fetch_pc_q <= ZERO_DATA;
      lsb_pend_q <= FALSE;
      lsb_req_q <= '0;
      fetch_ce_q <= FALSE;
      lsb_ce_q <= FALSE;
      instr_q <= ZERO_DATA;
      rdata_q <= ZERO_DATA;
    end else if (rdy) begin
      state_q <= state_d;
      stage_q <= stage_d;
      beats_q <= beats_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      asm_q <= asm_d;
      fetch_pend_q <= fetch_pend_d;
      fetch_pc_q <= fetch_pc_d;
      lsb_pend_q <= lsb_pend_d;
      lsb_req_q <= lsb_req_d;
      fetch_ce_q <= fetch_ce_d;
      lsb_ce_q <= lsb_ce_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end
  assign mem_a = state_q != ST_IDLE && stage_q < beats_q ? base_q + {29'd0, stage_q} : ZERO_DATA;
  assign mem_wr = storing && !io_stall;
  assign mem_dout = storing ? wdata_q[{stage_q[1:0], 3'b000} +: 8] : 8'h00;
  assign out_fetch_ce = fetch_ce_q;
  assign out_fetch_instr = instr_q;
  assign out_lsb_ce = lsb_ce_q;
  assign out_lsb_rdata = rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-array memory model
module tb_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic in_fetch_ce = 1'b0, in_lsb_ce = 1'b0, in_lsb_we = 1'b0;
  logic [31:0] in_fetch_pc = '0, in_lsb_addr = '0, in_lsb_wdata = '0;
  logic [1:0] in_lsb_size = '0;
  logic in_rob_misbranch = 1'b0, in_io_buffer_full = 1'b0;
  logic [7:0] mem_din = '0;
  logic out_fetch_ce, out_lsb_ce, mem_wr;
  logic [31:0] out_fetch_instr, out_lsb_rdata, mem_a;
  logic [7:0] mem_dout;
  logic [7:0] ram [int unsigned];
  logic [7:0] model [int unsigned];
  int checks = 0, failures = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetch_ce(in_fetch_ce), .in_fetch_pc(in_fetch_pc),
    .out_fetch_ce(out_fetch_ce), .out_fetch_instr(out_fetch_instr),
    .in_lsb_ce(in_lsb_ce), .in_lsb_we(in_lsb_we), .in_lsb_addr(in_lsb_addr),
    .in_lsb_size(in_lsb_size), .in_lsb_wdata(in_lsb_wdata),
    .out_lsb_ce(out_lsb_ce), .out_lsb_rdata(out_lsb_rdata),
    .in_rob_misbranch(in_rob_misbranch), .in_io_buffer_full(in_io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return model.exists(a) ? model[a] : 8'h00;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = model_rd(a + i);
    return w;
  endfunction

  // Byte RAM: read data appears the cycle after its address, gated by rdy like the real part.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= rd_ram(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    model[a] = b;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic run_op(input int kind, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    bit done;
    next();
    if (kind == 0) begin
      in_fetch_ce = 1'b1;
      in_fetch_pc = addr;
    end else begin
      in_lsb_ce = 1'b1;
      in_lsb_we = kind == 2;
      in_lsb_addr = addr;
      in_lsb_size = size;
      in_lsb_wdata = wd;
    end
    lat = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      next();
      in_fetch_ce = 1'b0;
      in_lsb_ce = 1'b0;
      lat++;
      smp();
      done = kind == 0 ? out_fetch_ce : out_lsb_ce;
    end
    rd = kind == 0 ? out_fetch_instr : out_lsb_rdata;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL op_timeout kind=%0d addr=%h no done within 40 cycles", kind, addr);
      lat = -1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next();
    next();
    smp();
    checks++;
    if ({out_fetch_ce, out_lsb_ce, mem_wr} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000", {out_fetch_ce, out_lsb_ce, mem_wr});
    end
    checks++;
    if ({mem_a, mem_dout} !== 40'h0) begin
      failures++;
      $display("FAIL reset_bus got a=%h dout=%h exp=0", mem_a, mem_dout);
    end
    checks++;
    if ({out_fetch_instr, out_lsb_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got instr=%h rdata=%h exp=0", out_fetch_instr, out_lsb_rdata);
    end
    next();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    next();
    in_fetch_ce = 1'b1;
    in_fetch_pc = 32'h100;
    smp();
    checks++;
    if ({mem_wr, mem_a} !== 33'h0) begin
      failures++;
      $display("FAIL fetch_idle_bus got wr=%b a=%h exp 0", mem_wr, mem_a);
    end
    for (int s = 0; s < 4; s++) begin
      next();
      in_fetch_ce = 1'b0;
      smp();
      checks++;
      if ({mem_wr, mem_a} !== {1'b0, 32'h100 + s}) begin
        failures++;
        $display("FAIL fetch_addr s=%0d got wr=%b a=%h exp a=%h", s, mem_wr, mem_a, 32'h100 + s);
      end
    end
    next();
    smp();
    checks++;
    if (out_fetch_ce !== 1'b0) begin
      failures++;
      $display("FAIL fetch_early_done got=%b exp=0 at t+4", out_fetch_ce);
    end
    next();
    smp();
    checks++;
    if ({out_fetch_ce, out_fetch_instr} !== {1'b1, 32'h00000513}) begin
      failures++;
      $display("FAIL fetch_done got ce=%b instr=%h exp ce=1 instr=00000513", out_fetch_ce, out_fetch_instr);
    end
    next();
    smp();
    checks++;
    if (out_fetch_ce !== 1'b0) begin
      failures++;
      $display("FAIL fetch_pulse_width got=%b exp=0", out_fetch_ce);
    end
  endtask

  task automatic test_priority();
    next();
    in_fetch_ce = 1'b1;
    in_fetch_pc = 32'h104;
    in_lsb_ce = 1'b1;
    in_lsb_we = 1'b0;
    in_lsb_addr = 32'h200;
    in_lsb_size = 2'b00;
    next();
    in_fetch_ce = 1'b0;
    in_lsb_ce = 1'b0;
    smp();
    checks++;
    if ({mem_wr, mem_a} !== {1'b0, 32'h200}) begin
      failures++;
      $display("FAIL prio_first_addr got wr=%b a=%h exp a=00000200", mem_wr, mem_a);
    end
    next();
    smp();
    checks++;
    if ({out_lsb_ce, out_fetch_ce} !== 2'b00) begin
      failures++;
      $display("FAIL prio_early_done got lsb=%b fetch=%b exp 00", out_lsb_ce, out_fetch_ce);
    end
    next();
    smp();
    checks++;
    if ({out_lsb_ce, out_lsb_rdata} !== {1'b1, 32'h000000FF}) begin
      failures++;
      $display("FAIL prio_load_done got ce=%b rdata=%h exp ce=1 rdata=000000ff", out_lsb_ce, out_lsb_rdata);
    end
    checks++;
    if (mem_a !== 32'h104) begin
      failures++;
      $display("FAIL prio_fetch_start got a=%h exp=00000104", mem_a);
    end
    repeat (4) next();
    smp();
    checks++;
    if (out_fetch_ce !== 1'b0) begin
      failures++;
      $display("FAIL prio_fetch_early got=%b exp=0", out_fetch_ce);
    end
    next();
    smp();
    checks++;
    if ({out_fetch_ce, out_fetch_instr} !== {1'b1, 32'h00100093}) begin
      failures++;
      $display("FAIL prio_fetch_done got ce=%b instr=%h exp ce=1 instr=00100093", out_fetch_ce, out_fetch_instr);
    end
  endtask

  task automatic test_store_word();
    logic [31:0] wd = 32'hDEADBEEF, rd;
    int lat;
    next();
    in_lsb_ce = 1'b1;
    in_lsb_we = 1'b1;
    in_lsb_addr = 32'h400;
    in_lsb_size = 2'b10;
    in_lsb_wdata = wd;
    for (int s = 0; s < 4; s++) begin
      next();
      in_lsb_ce = 1'b0;
      smp();
      checks++;
      if ({out_lsb_ce, mem_wr, mem_a, mem_dout} !== {1'b0, 1'b1, 32'h400 + s, wd[8*s +: 8]}) begin
        failures++;
        $display("FAIL store_beat s=%0d got ce=%b wr=%b a=%h dout=%h exp wr=1 a=%h dout=%h",
                 s, out_lsb_ce, mem_wr, mem_a, mem_dout, 32'h400 + s, wd[8*s +: 8]);
      end
      model[32'h400 + s] = wd[8*s +: 8];
    end
    next();
    smp();
    checks++;
    if ({out_lsb_ce, mem_wr} !== 2'b10) begin
      failures++;
      $display("FAIL store_done got ce=%b wr=%b exp ce=1 wr=0", out_lsb_ce, mem_wr);
    end
    run_op(1, 32'h400, 2'b10, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || lat != 6) begin
      failures++;
      $display("FAIL store_readback got=%h lat=%0d exp=deadbeef lat=6", rd, lat);
    end
  endtask

  task automatic test_io_stall();
    next();
    in_lsb_ce = 1'b1;
    in_lsb_we = 1'b1;
    in_lsb_addr = 32'h30000;
    in_lsb_size = 2'b00;
    in_lsb_wdata = 32'h41;
    in_io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next();
      in_lsb_ce = 1'b0;
      smp();
      checks++;
      if ({mem_wr, out_lsb_ce} !== 2'b00) begin
        failures++;
        $display("FAIL io_stall k=%0d got wr=%b ce=%b exp 00", k, mem_wr, out_lsb_ce);
      end
    end
    next();
    in_io_buffer_full = 1'b0;
    smp();
    checks++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h41}) begin
      failures++;
      $display("FAIL io_write got wr=%b a=%h dout=%h exp wr=1 a=00030000 dout=41", mem_wr, mem_a, mem_dout);
    end
    model[32'h30000] = 8'h41;
    next();
    smp();
    checks++;
    if ({out_lsb_ce, mem_wr} !== 2'b10) begin
      failures++;
      $display("FAIL io_done got ce=%b wr=%b exp ce=1 wr=0", out_lsb_ce, mem_wr);
    end
  endtask

  task automatic test_misbranch();
    bit seen = 1'b0;
    logic [31:0] rd;
    int lat;
    next();
    in_fetch_ce = 1'b1;
    in_fetch_pc = 32'h500;
    next();
    in_fetch_ce = 1'b0;
    smp();
    checks++;
    if (mem_a !== 32'h500) begin
      failures++;
      $display("FAIL mb_fetch_start got a=%h exp=00000500", mem_a);
    end
    next();
    in_rob_misbranch = 1'b1;
    next();
    in_rob_misbranch = 1'b0;
    smp();
    checks++;
    if ({mem_wr, mem_a} !== 33'h0) begin
      failures++;
      $display("FAIL mb_idle got wr=%b a=%h exp 0", mem_wr, mem_a);
    end
    repeat (6) begin
      if (out_fetch_ce) seen = 1'b1;
      next();
      smp();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mb_no_done got a fetch done pulse exp none");
    end
    run_op(0, 32'h104, 2'b00, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h00100093 || lat != 6) begin
      failures++;
      $display("FAIL mb_refetch got=%h lat=%0d exp=00100093 lat=6", rd, lat);
    end
  endtask

  task automatic test_misbranch_drop();
    bit seen = 1'b0;
    next();
    in_lsb_ce = 1'b1;
    in_lsb_we = 1'b0;
    in_lsb_addr = 32'h1000;
    in_lsb_size = 2'b10;
    in_rob_misbranch = 1'b1;
    repeat (6) begin
      next();
      in_lsb_ce = 1'b0;
      in_rob_misbranch = 1'b0;
      smp();
      if (out_lsb_ce || mem_a !== 32'h0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mb_load_dropped got bus activity or done exp none");
    end
    next();
    in_lsb_ce = 1'b1;
    in_lsb_we = 1'b1;
    in_lsb_addr = 32'h1200;
    in_lsb_size = 2'b00;
    in_lsb_wdata = 32'h5A;
    in_rob_misbranch = 1'b1;
    next();
    in_lsb_ce = 1'b0;
    in_rob_misbranch = 1'b0;
    smp();
    checks++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h1200, 8'h5A}) begin
      failures++;
      $display("FAIL mb_store_kept got wr=%b a=%h dout=%h exp wr=1 a=00001200 dout=5a", mem_wr, mem_a, mem_dout);
    end
    model[32'h1200] = 8'h5A;
    next();
    smp();
    checks++;
    if (out_lsb_ce !== 1'b1) begin
      failures++;
      $display("FAIL mb_store_done got=%b exp=1", out_lsb_ce);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int lat;
    preload(32'hFFFFFFFE, 8'hA1);
    preload(32'hFFFFFFFF, 8'hB2);
    preload(32'h0, 8'hC3);
    preload(32'h1, 8'hD4);
    run_op(1, 32'hFFFFFFFE, 2'b10, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hD4C3B2A1) begin
      failures++;
      $display("FAIL wrap_word got=%h exp=d4c3b2a1", rd);
    end
    run_op(1, 32'hFFFFFFFF, 2'b01, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000C3B2 || lat != 4) begin
      failures++;
      $display("FAIL wrap_half got=%h lat=%0d exp=0000c3b2 lat=4", rd, lat);
    end
  endtask

  task automatic test_random();
    int kind, n, lat, errs = 0;
    logic [31:0] addr, wd, exp, rd;
    logic [1:0] sz;
    for (int a = 32'h1000; a < 32'h1104; a++) preload(a, 8'($urandom));
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 2);
      addr = 32'h1000 + $urandom_range(0, 255);
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      n = kind == 0 ? 4 : sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
      exp = exp_read(addr, n);
      run_op(kind, addr, sz, wd, rd, lat);
      if (kind == 2) begin
        for (int i = 0; i < n; i++) model[addr + i] = wd[8*i +: 8];
        checks++;
        if (lat != n + 1) begin
          failures++;
          $display("FAIL rand_store_lat k=%0d got=%0d exp=%0d", k, lat, n + 1);
        end
      end else begin
        checks++;
        if (rd !== exp || lat != n + 2) begin
          failures++;
          $display("FAIL rand_read k=%0d kind=%0d addr=%h size=%0d got=%h lat=%0d exp=%h lat=%0d",
                   k, kind, addr, sz, rd, lat, exp, n + 2);
        end
      end
    end
    foreach (model[a]) if (rd_ram(a) !== model[a]) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL ram_image got %0d differing bytes exp 0", errs);
    end
  endtask

  task automatic test_reset_mid_store();
    bit seen = 1'b0;
    next();
    in_lsb_ce = 1'b1;
    in_lsb_we = 1'b1;
    in_lsb_addr = 32'h600;
    in_lsb_size = 2'b10;
    in_lsb_wdata = 32'h11223344;
    next();
    in_lsb_ce = 1'b0;
    next();
    rst = 1'b1;
    smp();
    checks++;
    if (mem_wr !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_active got wr=%b exp=1", mem_wr);
    end
    next();
    rst = 1'b0;
    smp();
    checks++;
    if ({out_fetch_ce, out_lsb_ce, mem_wr, mem_a, mem_dout, out_fetch_instr, out_lsb_rdata} !== 107'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs got ce=%b%b wr=%b a=%h dout=%h instr=%h rdata=%h exp all 0",
               out_fetch_ce, out_lsb_ce, mem_wr, mem_a, mem_dout, out_fetch_instr, out_lsb_rdata);
    end
    repeat (6) begin
      next();
      smp();
      if (out_lsb_ce || mem_wr) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_mid_no_done got done or write after reset exp none");
    end
  endtask

  initial begin
    preload(32'h100, 8'h13);
    preload(32'h101, 8'h05);
    preload(32'h102, 8'h00);
    preload(32'h103, 8'h00);
    preload(32'h104, 8'h93);
    preload(32'h105, 8'h00);
    preload(32'h106, 8'h10);
    preload(32'h107, 8'h00);
    preload(32'h200, 8'hFF);
    for (int a = 32'h500; a < 32'h504; a++) preload(a, 8'($urandom));
    test_reset();
    test_fetch();
    test_priority();
    test_store_word();
    test_io_stall();
    test_misbranch();
    test_misbranch_drop();
    test_wrap();
    test_random();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
